// File: rtl/muldiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl_if
// Description : Request, response and M-unit bus of the mul/div issue
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_ctrl_if #(
  parameter int XLEN = 32
) ();
  logic            i_valid;
  logic            o_ready;
  logic [6:0]      i_opcode;
  logic [6:0]      i_funct7;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic [4:0]      i_rd;
  logic            i_flush;
  logic [XLEN-1:0] o_unit_in1;
  logic [XLEN-1:0] o_unit_in2;
  logic [6:0]      o_unit_opcode;
  logic [6:0]      o_unit_funct7;
  logic [2:0]      o_unit_funct3;
  logic [XLEN-1:0] i_unit_result;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic [4:0]      o_rd;
  logic            o_busy;

  // Execute stage, downstream consumer and M-unit side.
  modport master (
    output i_valid, i_opcode, i_funct7, i_funct3, i_rs1, i_rs2, i_rd, i_flush,
    output i_unit_result, i_ready,
    input  o_ready, o_unit_in1, o_unit_in2, o_unit_opcode, o_unit_funct7,
    input  o_unit_funct3, o_valid, o_result, o_rd, o_busy
  );

  // Controller side.
  modport slave (
    input  i_valid, i_opcode, i_funct7, i_funct3, i_rs1, i_rs2, i_rd, i_flush,
    input  i_unit_result, i_ready,
    output o_ready, o_unit_in1, o_unit_in2, o_unit_opcode, o_unit_funct7,
    output o_unit_funct3, o_valid, o_result, o_rd, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : Multi-cycle issue controller for a combinational M-extension
//               unit, with in-block RISC-V divide special cases.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  wire logic     i_clk,
  input  wire logic     i_rst_n,
  muldiv_ctrl_if.slave  bus
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] c_MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [XLEN-1:0]  c_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  c_ONES     = {XLEN{1'b1}};

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic            r_bypass_vld;
  logic [XLEN-1:0] r_bypass_val;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_unit_in1;
  logic [XLEN-1:0] r_unit_in2;
  logic [6:0]      r_unit_opcode;
  logic [6:0]      r_unit_funct7;
  logic [2:0]      r_unit_funct3;
  logic            r_valid;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_out_rd;

  logic            w_ready;
  logic            w_is_m;
  logic            w_accept;
  logic            w_div_zero;
  logic            w_overflow;
  logic            w_special;
  logic [XLEN-1:0] w_bypass_val;

  assign w_is_m   = (bus.i_opcode == 7'b0110011) && (bus.i_funct7 == 7'b0000001);
  assign w_accept = bus.i_valid && w_ready && w_is_m && !bus.i_flush;

  // funct3[2] selects divide, funct3[1] remainder, funct3[0] unsigned.
  assign w_div_zero = bus.i_funct3[2] && (bus.i_rs2 == '0);
  assign w_overflow = bus.i_funct3[2] && !bus.i_funct3[0] &&
                      (bus.i_rs1 == c_INT_MIN) && (bus.i_rs2 == c_ONES);
  assign w_special  = w_div_zero || w_overflow;

  always_comb begin
    w_bypass_val = '0;
    if (w_div_zero)
      w_bypass_val = bus.i_funct3[1] ? bus.i_rs1 : c_ONES;
    else if (w_overflow)
      w_bypass_val = bus.i_funct3[1] ? '0 : c_INT_MIN;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= c_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (bus.i_flush) begin
      w_next_state = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE:  if (w_accept) w_next_state = c_WAIT;
        c_WAIT:  if (r_cnt == '0) w_next_state = c_DONE;
        c_DONE: begin
          if (w_accept)         w_next_state = c_WAIT;
          else if (bus.i_ready) w_next_state = c_IDLE;
        end
        default: w_next_state = c_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ready    = (r_state == c_IDLE) || ((r_state == c_DONE) && bus.i_ready);
    bus.o_busy = (r_state != c_IDLE);
  end
  assign bus.o_ready = w_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt         <= '0;
      r_bypass_vld  <= 1'b0;
      r_bypass_val  <= '0;
      r_rd          <= '0;
      r_unit_in1    <= '0;
      r_unit_in2    <= '0;
      r_unit_opcode <= '0;
      r_unit_funct7 <= '0;
      r_unit_funct3 <= '0;
      r_valid       <= 1'b0;
      r_result      <= '0;
      r_out_rd      <= '0;
    end else if (bus.i_flush) begin
      r_valid       <= 1'b0;
      r_unit_opcode <= '0;
      r_cnt         <= '0;
      r_bypass_vld  <= 1'b0;
    end else begin
      if ((r_state == c_DONE) && bus.i_ready)
        r_valid <= 1'b0;
      if (r_state == c_WAIT) begin
        if (r_cnt == '0) begin
          r_result      <= r_bypass_vld ? r_bypass_val : bus.i_unit_result;
          r_out_rd      <= r_rd;
          r_valid       <= 1'b1;
          r_unit_opcode <= '0;
          r_bypass_vld  <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
      // Accept only happens in IDLE/DONE, so it never races the capture above.
      if (w_accept) begin
        r_unit_in1    <= bus.i_rs1;
        r_unit_in2    <= bus.i_rs2;
        r_unit_opcode <= bus.i_opcode;
        r_unit_funct7 <= bus.i_funct7;
        r_unit_funct3 <= bus.i_funct3;
        r_rd          <= bus.i_rd;
        r_bypass_vld  <= w_special;
        r_bypass_val  <= w_bypass_val;
        r_cnt         <= w_special ? '0 : (bus.i_funct3[2] ? c_DIV_LOAD : c_MUL_LOAD);
      end
    end
  end

  assign bus.o_unit_in1    = r_unit_in1;
  assign bus.o_unit_in2    = r_unit_in2;
  assign bus.o_unit_opcode = r_unit_opcode;
  assign bus.o_unit_funct7 = r_unit_funct7;
  assign bus.o_unit_funct3 = r_unit_funct3;
  assign bus.o_valid       = r_valid;
  assign bus.o_result      = r_result;
  assign bus.o_rd          = r_out_rd;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Directed self-checking bench for muldiv_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic corrupt_unit;

  muldiv_ctrl_if #(.XLEN(32)) bus ();

  muldiv_ctrl #(.XLEN(32), .MUL_CYCLES(2), .DIV_CYCLES(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational M unit; corrupt_unit proves bypass results ignore it.
  function automatic logic [31:0] unit_model(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    unit_model = 32'h0;
    if (op != 7'h0) begin
      case (f3)
        3'b000: begin p = {32'h0, a} * {32'h0, b}; unit_model = p[31:0]; end
        3'b011: begin p = {32'h0, a} * {32'h0, b}; unit_model = p[63:32]; end
        3'b101: unit_model = (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'b111: unit_model = (b == 0) ? a : a % b;
        default: unit_model = 32'h0;
      endcase
    end
  endfunction

  always_comb begin
    bus.i_unit_result = corrupt_unit ? 32'hDEAD_BEEF :
      unit_model(bus.o_unit_opcode, bus.o_unit_funct3, bus.o_unit_in1, bus.o_unit_in2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [6:0] f7, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.i_valid  = 1'b1;
    bus.i_opcode = 7'b0110011;
    bus.i_funct7 = f7;
    bus.i_funct3 = f3;
    bus.i_rs1    = a;
    bus.i_rs2    = b;
    bus.i_rd     = rd;
  endtask

  task automatic test_reset();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
    checks++; if (bus.o_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.o_result); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_unit_opcode !== 7'h0) begin errors++; $display("FAIL reset_unit_opcode: got %h want 0", bus.o_unit_opcode); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.o_ready); end
  endtask

  task automatic test_mul();
    bus.i_ready = 1'b1;
    drive_req(7'h01, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
    tick();
    bus.i_valid = 1'b0;
    checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL mul_ready_wait: got %b want 0", bus.o_ready); end
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL mul_busy: got %b want 1", bus.o_busy); end
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL mul_early_valid: got %b want 0", bus.o_valid); end
    tick();
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL mul_valid: got %b want 1", bus.o_valid); end
    checks++; if (bus.o_result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h want ffffffeb", bus.o_result); end
    checks++; if (bus.o_rd !== 5'd5) begin errors++; $display("FAIL mul_rd: got %0d want 5", bus.o_rd); end
    checks++; if (bus.o_unit_opcode !== 7'h0) begin errors++; $display("FAIL mul_done_opcode: got %h want 0", bus.o_unit_opcode); end
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL mul_valid_one_cycle: got %b want 0", bus.o_valid); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL mul_back_idle: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_back_to_back();
    bus.i_ready = 1'b1;
    drive_req(7'h01, 3'b101, 32'd100, 32'd7, 5'd9);
    tick();
    bus.i_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (bus.o_valid !== 1'b0 || bus.o_unit_in1 !== 32'd100 || bus.o_unit_in2 !== 32'd7 ||
          bus.o_unit_funct3 !== 3'b101 || bus.o_unit_opcode !== 7'b0110011) begin
        errors++;
        $display("FAIL divu_hold_%0d: got valid=%b in1=%0d in2=%0d f3=%b op=%h want 0/100/7/101/33",
                 k, bus.o_valid, bus.o_unit_in1, bus.o_unit_in2, bus.o_unit_funct3, bus.o_unit_opcode);
      end
    end
    tick();
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL divu_valid: got %b want 1", bus.o_valid); end
    checks++; if (bus.o_result !== 32'd14) begin errors++; $display("FAIL divu_result: got %0d want 14", bus.o_result); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL done_ready: got %b want 1", bus.o_ready); end
    drive_req(7'h01, 3'b111, 32'd100, 32'd7, 5'd10);
    tick();
    bus.i_valid = 1'b0;
    checks++; if (bus.o_busy !== 1'b1 || bus.o_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_bubble: got busy=%b valid=%b want 1/0", bus.o_busy, bus.o_valid); end
    checks++; if (bus.o_unit_funct3 !== 3'b111) begin errors++; $display("FAIL b2b_funct3: got %b want 111", bus.o_unit_funct3); end
    for (int k = 1; k <= 7; k++) tick();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL remu_early_valid: got %b want 0", bus.o_valid); end
    tick();
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL remu_valid: got %b want 1", bus.o_valid); end
    checks++; if (bus.o_result !== 32'd2) begin errors++; $display("FAIL remu_result: got %0d want 2", bus.o_result); end
    checks++; if (bus.o_rd !== 5'd10) begin errors++; $display("FAIL remu_rd: got %0d want 10", bus.o_rd); end
    tick();
  endtask

  task automatic test_special();
    bus.i_ready  = 1'b1;
    corrupt_unit = 1'b1;
    drive_req(7'h01, 3'b100, 32'd123, 32'd0, 5'd3);
    tick();
    bus.i_valid = 1'b0;
    tick();
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL div0_valid: got %b want 1", bus.o_valid); end
    checks++; if (bus.o_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_result: got %h want ffffffff", bus.o_result); end
    tick();
    drive_req(7'h01, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    tick();
    bus.i_valid = 1'b0;
    tick();
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL removf_valid: got %b want 1", bus.o_valid); end
    checks++; if (bus.o_result !== 32'h0) begin errors++; $display("FAIL removf_result: got %h want 0", bus.o_result); end
    tick();
    drive_req(7'h01, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    tick();
    bus.i_valid = 1'b0;
    tick();
    checks++; if (bus.o_result !== 32'h8000_0000) begin errors++; $display("FAIL divovf_result: got %h want 80000000", bus.o_result); end
    drive_req(7'h01, 3'b111, 32'd55, 32'd0, 5'd8);
    tick();
    bus.i_valid = 1'b0;
    tick();
    checks++; if (bus.o_result !== 32'd55) begin errors++; $display("FAIL remu0_result: got %0d want 55", bus.o_result); end
    tick();
    corrupt_unit = 1'b0;
  endtask

  task automatic test_backpressure();
    bus.i_ready = 1'b0;
    drive_req(7'h01, 3'b000, 32'd6, 32'd7, 5'd12);
    tick();
    drive_req(7'h01, 3'b000, 32'd2, 32'd3, 5'd13);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_result !== 32'd42 || bus.o_rd !== 5'd12 || bus.o_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b result=%0d rd=%0d ready=%b want 1/42/12/0",
                 k, bus.o_valid, bus.o_result, bus.o_rd, bus.o_ready);
      end
      tick();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL bp_still_valid: got %b want 1", bus.o_valid); end
    tick();
    checks++; if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL bp_release: got valid=%b busy=%b want 0/0", bus.o_valid, bus.o_busy); end
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL bp_single_transfer: got %b want 0", bus.o_valid); end
  endtask

  task automatic test_flush();
    logic seen_valid;
    bus.i_ready = 1'b1;
    drive_req(7'h01, 3'b101, 32'd50, 32'd5, 5'd7);
    tick();
    bus.i_valid = 1'b0;
    tick();
    tick();
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL flush_idle: got busy=%b want 0", bus.o_busy); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", bus.o_ready); end
    checks++; if (bus.o_unit_opcode !== 7'h0) begin errors++; $display("FAIL flush_opcode: got %h want 0", bus.o_unit_opcode); end
    seen_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.o_valid !== 1'b0) seen_valid = 1'b1;
    end
    checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL flush_no_result: got valid seen=%b want 0", seen_valid); end
    drive_req(7'h01, 3'b000, 32'd3, 32'd3, 5'd1);
    bus.i_flush = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL flush_blocks_accept: got busy=%b want 0", bus.o_busy); end
  endtask

  task automatic test_async_reset();
    bus.i_ready = 1'b1;
    drive_req(7'h01, 3'b101, 32'd9, 32'd2, 5'd11);
    tick();
    bus.i_valid = 1'b0;
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b want 1", bus.o_busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_busy !== 1'b0 || bus.o_unit_opcode !== 7'h0 || bus.o_unit_in1 !== 32'h0) begin
      errors++;
      $display("FAIL rst_async: got busy=%b op=%h in1=%h want 0/0/0", bus.o_busy, bus.o_unit_opcode, bus.o_unit_in1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive_req(7'h00, 3'b000, 32'd4, 32'd4, 5'd2);
    tick();
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL nonm_ignored: got busy=%b want 0", bus.o_busy); end
    bus.i_valid = 1'b0;
    tick();
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL nonm_no_result: got %b want 0", bus.o_valid); end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    corrupt_unit = 1'b0;
    rst_n        = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_opcode = 7'h0;
    bus.i_funct7 = 7'h0;
    bus.i_funct3 = 3'h0;
    bus.i_rs1    = 32'h0;
    bus.i_rs2    = 32'h0;
    bus.i_rd     = 5'h0;
    bus.i_flush  = 1'b0;
    bus.i_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_reset();
    test_mul();
    test_back_to_back();
    test_special();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Multi-cycle issue controller for the combinational M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). It accepts one operation from the execute stage through a valid/ready handshake and registers the operands. It holds those operands stable on the unit's inputs for a fixed multicycle budget (separate budgets for multiply and divide), captures the result, and returns it through a valid/ready handshake. RISC-V divide special cases are resolved in-block and bypass the unit's wait budget.

Parameters:
XLEN, 32, operand/result width
MUL_CYCLES, 2, clock edges the unit inputs are held for funct3[2]=0 before result capture (>=1)
DIV_CYCLES, 8, clock edges held for funct3[2]=1 before result capture (>=1)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  request valid from execute stage
o_ready  output  1  controller can accept a request
i_opcode  input  7  instruction opcode
i_funct7  input  7  instruction funct7
i_funct3  input  3  M-extension operation select
i_rs1  input  XLEN  operand 1
i_rs2  input  XLEN  operand 2
i_rd  input  5  destination register tag
i_flush  input  1  pipeline flush, kills the in-flight op
o_unit_in1  output  XLEN  registered operand 1 to the unit
o_unit_in2  output  XLEN  registered operand 2 to the unit
o_unit_opcode  output  7  registered opcode to the unit; 0 when idle
o_unit_funct7  output  7  registered funct7 to the unit
o_unit_funct3  output  3  registered funct3 to the unit
i_unit_result  input  XLEN  unit combinational result
o_valid  output  1  result valid
i_ready  input  1  downstream accepts the result
o_result  output  XLEN  captured result
o_rd  output  5  destination tag of the result
o_busy  output  1  op in flight (state != IDLE), used as a stall

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, counter=0. All registered outputs 0: o_valid, o_result, o_rd, o_busy and all o_unit_*. o_ready=1 once reset is released. Reset mid-operation drops the op with no result.
- is_m = (i_opcode==7'b0110011) && (i_funct7==7'b0000001). accept = i_valid && o_ready && is_m && !i_flush.
- A non-M request with i_valid=1 is ignored: no state change, no result.
- States: IDLE, WAIT, DONE.
- o_ready=1 in IDLE, and in DONE when i_ready=1 (back-to-back issue). Otherwise 0.
- IDLE --accept--> action depends on the operation:
  - Normal op: register operands, opcode, funct7, funct3 and rd onto o_unit_*. Load counter with (funct3[2] ? DIV_CYCLES : MUL_CYCLES) - 1. Go to WAIT.
  - Special op: go to WAIT with counter=0 and a bypass value latched. Special cases:
    - funct3 DIV/DIVU with rs2==0: result all-ones.
    - funct3 REM/REMU with rs2==0: result rs1.
    - funct3 DIV with rs1==0x80000000 and rs2==all-ones: result 0x80000000.
    - funct3 REM with the same overflow operands: result 0.
- WAIT: counter decrements each edge. At the edge where counter==0:
  - o_result <= bypass valid ? bypass value : i_unit_result.
  - o_rd <= registered rd, o_valid <= 1, go to DONE.
- Latency: with accept at edge E0, o_valid is high after edge E_N, where N = MUL_CYCLES, DIV_CYCLES, or 1 for special cases.
- DONE: o_valid, o_result and o_rd are held stable while i_ready=0.
  - On i_ready=1: o_valid <= 0 and go to IDLE.
  - If a new accept happens in the same cycle, go directly to WAIT instead.
- o_unit_* hold constant from accept until result capture. In IDLE and DONE, o_unit_opcode=0 so the unit outputs 0.
- i_flush, any state: next state IDLE, o_valid <= 0, o_unit_opcode <= 0, counter <= 0, result discarded.
- Flush takes priority over accept and capture in the same cycle.
- o_busy = (state != IDLE).

Test Plan:
- MUL, funct3=000, rs1=7, rs2=0xFFFFFFFD, MUL_CYCLES=2, i_ready=1 -> o_valid high after 2nd edge past accept for exactly 1 cycle; o_result=0xFFFFFFEB; o_rd echoes i_rd; o_ready low during WAIT.
- DIVU, rs1=100, rs2=7, DIV_CYCLES=8 -> o_unit_* stable for 8 edges; o_result=14; then REMU on the same operands back-to-back, issued in DONE with i_ready=1 -> o_result=2 with no idle bubble.
- DIV with rs2=0 -> o_result=0xFFFFFFFF after 1 edge. REM with rs1=0x80000000, rs2=0xFFFFFFFF -> o_result=0 after 1 edge. Unit output is ignored in both cases.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid, o_result and o_rd unchanged, o_ready=0, new i_valid is not accepted; release i_ready -> one transfer only.
- i_flush asserted at 3rd cycle of an 8-cycle DIV -> state IDLE next cycle, o_valid never asserts, o_ready=1. Flush together with i_valid -> no accept.
- i_rst_n pulsed low mid-WAIT -> outputs 0 immediately (async). A non-M op (funct7=0) with i_valid=1 -> ignored, o_busy stays 0.
